// File: rtl/hamming16.sv
// 16-bit population counter built as a balanced adder tree, with combinational
// parity/zero/full flags and a registered copy of the count.
module hamming16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] x,
   output logic [4:0]  count,
   output logic [4:0]  count_q,
   output logic        parity,
   output logic        zero,
   output logic        full
);

   // Each tree level widens its result by one bit so no carry is dropped.
   function automatic logic [1:0] sum_l1(input logic a, input logic b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   function automatic logic [2:0] sum_l2(input logic [1:0] a, input logic [1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   function automatic logic [3:0] sum_l3(input logic [2:0] a, input logic [2:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   function automatic logic [4:0] sum_l4(input logic [3:0] a, input logic [3:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   function automatic logic parity16(input logic [15:0] v);
      return ^v;
   endfunction

   logic [1:0] l1_s [8];
   logic [2:0] l2_s [4];
   logic [3:0] l3_s [2];
   logic [4:0] sum_s;
   logic [4:0] count_d;
   logic [4:0] count_reg_q;

   // Level 1: adjacent bit pairs.
   always_comb begin
      l1_s[0] = sum_l1(x[0],  x[1]);
      l1_s[1] = sum_l1(x[2],  x[3]);
      l1_s[2] = sum_l1(x[4],  x[5]);
      l1_s[3] = sum_l1(x[6],  x[7]);
      l1_s[4] = sum_l1(x[8],  x[9]);
      l1_s[5] = sum_l1(x[10], x[11]);
      l1_s[6] = sum_l1(x[12], x[13]);
      l1_s[7] = sum_l1(x[14], x[15]);
   end

   // Levels 2-4: fold the partial sums down to a single 5-bit total.
   always_comb begin
      l2_s[0] = sum_l2(l1_s[0], l1_s[1]);
      l2_s[1] = sum_l2(l1_s[2], l1_s[3]);
      l2_s[2] = sum_l2(l1_s[4], l1_s[5]);
      l2_s[3] = sum_l2(l1_s[6], l1_s[7]);
      l3_s[0] = sum_l3(l2_s[0], l2_s[1]);
      l3_s[1] = sum_l3(l2_s[2], l2_s[3]);
      sum_s   = sum_l4(l3_s[0], l3_s[1]);
   end

   assign count   = sum_s;
   assign parity  = parity16(x);
   assign zero    = (sum_s == 5'd0);
   assign full    = (sum_s == 5'd16);
   assign count_d = sum_s;

   // Registered count; cleared asynchronously and held at zero during reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg_q <= 5'd0;
      end else begin
         count_reg_q <= count_d;
      end
   end

   assign count_q = count_reg_q;

endmodule

// File: tb/tb_hamming16.sv
// Self-checking bench for hamming16: exhaustive sweep, directed corners,
// registered path, mid-operation reset and randomized registered traffic.
module tb_hamming16;

   logic        clk;
   logic        rst_n;
   logic [15:0] x;
   logic [4:0]  count;
   logic [4:0]  count_q;
   logic        parity;
   logic        zero;
   logic        full;

   int checks;
   int errors;

   hamming16 dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .x       (x),
      .count   (count),
      .count_q (count_q),
      .parity  (parity),
      .zero    (zero),
      .full    (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: count ones one bit at a time.
   function automatic int ref_pop(input logic [15:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 16; i++) begin
         if (v[i] === 1'b1) n = n + 1;
      end
      return n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_comb(input string tag, input logic [15:0] v);
      int e;
      e = ref_pop(v);
      chk({tag, "_count"},  {27'd0, count}, e);
      chk({tag, "_parity"}, {31'd0, parity}, e % 2);
      chk({tag, "_zero"},   {31'd0, zero}, (e == 0) ? 1 : 0);
      chk({tag, "_full"},   {31'd0, full}, (e == 16) ? 1 : 0);
   endtask

   initial begin
      int exp_q;
      logic [15:0] r;
      checks = 0;
      errors = 0;

      rst_n = 1'b0;
      x     = 16'h0000;
      #1;
      chk("reset_count_q", {27'd0, count_q}, 0);
      chk("x0000_count",  {27'd0, count}, 0);
      chk("x0000_zero",   {31'd0, zero}, 1);
      chk("x0000_full",   {31'd0, full}, 0);
      chk("x0000_parity", {31'd0, parity}, 0);

      @(posedge clk);
      #1;
      chk("reset_hold_count_q", {27'd0, count_q}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 65536; v++) begin
         int e;
         x = v[15:0];
         #1;
         e = ref_pop(v[15:0]);
         checks++;
         assert ((count === e[4:0]) && (parity === e[0]))
         else begin
            errors++;
            $error("FAIL sweep x=%04h count=%0d parity=%0b expected=%0d", v[15:0], count, parity, e);
            $fatal(1, "sweep stopped at first error");
         end
      end

      @(negedge clk);
      x = 16'hFFFF; #1;
      chk("xFFFF_count",  {27'd0, count}, 16);
      chk("xFFFF_full",   {31'd0, full}, 1);
      chk("xFFFF_zero",   {31'd0, zero}, 0);
      chk("xFFFF_parity", {31'd0, parity}, 0);
      x = 16'h8001; #1;
      chk("x8001_count", {27'd0, count}, 2);
      x = 16'h5555; #1;
      chk("x5555_count", {27'd0, count}, 8);
      x = 16'h0007; #1;
      chk("x0007_count",  {27'd0, count}, 3);
      chk("x0007_parity", {31'd0, parity}, 1);

      @(negedge clk);
      x = 16'h00FF;
      @(posedge clk);
      #1;
      chk("reg_00FF_count_q", {27'd0, count_q}, 8);

      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_count_q", {27'd0, count_q}, 0);
      chk("midrst_count",   {27'd0, count}, 8);
      @(posedge clk);
      #1;
      chk("midrst_hold_count_q", {27'd0, count_q}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("release_count_q", {27'd0, count_q}, 0);
      @(posedge clk);
      #1;
      chk("release_edge_count_q", {27'd0, count_q}, 8);

      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         r = 16'($urandom);
         if (k % 17 == 0) r = 16'hFFFF;
         if (k % 19 == 0) r = 16'h0000;
         x = r;
         exp_q = ref_pop(r);
         #1;
         chk_comb("rand", r);
         @(posedge clk);
         #1;
         chk("rand_count_q", {27'd0, count_q}, exp_q);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
